booth4_pp_seq: RTL and testbench

BOOTH4_PP_SEQ -- requirements
Module: booth4_pp_seq

---
 rtl/booth4_pkg.sv | 48 ++++
 rtl/inv_converter_16.sv | 13 +
 rtl/booth4_pp_seq.sv | 121 ++++++++++++
 tb/tb_booth4_pp_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth4_pkg.sv
// Shared constants and helpers for the radix-4 Booth partial-product generator.
package booth4_pkg;

  // Partial-product width: a 16-bit operand times a Booth digit in -2..+2.
  localparam int PP_W = 18;

  // Number of radix-4 digits in a 16-bit multiplier.
  localparam int N_PP = 8;

  // Booth digit encodings {Y[2i+1], Y[2i], Y[2i-1]}.
  localparam logic [2:0] DIG_ZERO_LO = 3'b000;
  localparam logic [2:0] DIG_PX_A    = 3'b001;
  localparam logic [2:0] DIG_PX_B    = 3'b010;
  localparam logic [2:0] DIG_P2X     = 3'b011;
  localparam logic [2:0] DIG_M2X     = 3'b100;
  localparam logic [2:0] DIG_MX_A    = 3'b101;
  localparam logic [2:0] DIG_MX_B    = 3'b110;
  localparam logic [2:0] DIG_ZERO_HI = 3'b111;

  // Sequencer states, kept as plain constants for older tool flows.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GEN  = 1'b1;

  // Multiple of X selected by one Booth digit.
  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_PX   = 3'd1,
    SEL_P2X  = 3'd2,
    SEL_MX   = 3'd3,
    SEL_M2X  = 3'd4
  } pp_sel_e;

  // Map a 3-bit Booth window onto the multiple of X it stands for.
  function automatic pp_sel_e booth_decode(input logic [2:0] trip);
    pp_sel_e sel;
    sel = SEL_ZERO;
    case (trip)
      DIG_ZERO_LO, DIG_ZERO_HI: sel = SEL_ZERO;
      DIG_PX_A, DIG_PX_B:       sel = SEL_PX;
      DIG_P2X:                  sel = SEL_P2X;
      DIG_M2X:                  sel = SEL_M2X;
      DIG_MX_A, DIG_MX_B:       sel = SEL_MX;
      default:                  sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/inv_converter_16.sv
// Two's-complement negation of a signed 16-bit value into 17 bits, so that
// negating -32768 gives +32768 without wrapping.
module inv_converter_16 (
  input  logic [15:0] data_i,
  output logic [16:0] neg_o
);

  // Sign-extend by one bit before negating so the result always fits.
  always_comb begin
    neg_o = ~{data_i[15], data_i} + 17'd1;
  end

endmodule

// File: rtl/booth4_pp_seq.sv
// Sequential radix-4 Booth partial-product generator: accepts one X/Y pair,
// then streams the eight unshifted partial products over a valid/ready port.
module booth4_pp_seq #(
  parameter int N_PP = booth4_pkg::N_PP
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [15:0]                 mcand_i,
  input  logic [15:0]                 mplier_i,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [booth4_pkg::PP_W-1:0] pp_o,
  output logic [2:0]                  pp_idx_o,
  output logic                        pp_last_o
);

  import booth4_pkg::*;

  localparam logic [2:0] IDX_LAST = 3'(N_PP - 1);

  logic [0:0]      state_q, state_d;
  logic [15:0]     x_q, x_d;
  logic [15:0]     y_q, y_d;
  logic [2:0]      idx_q, idx_d;

  logic            accept;
  logic            pp_fire;
  logic            is_last;
  logic [16:0]     neg_x;
  logic [16:0]     y_ext;
  logic [2:0]      trip;
  pp_sel_e         sel;
  logic [PP_W-1:0] x_ext;
  logic [PP_W-1:0] neg_ext;
  logic [PP_W-1:0] pp_raw;

  // -X comes from the shared negation block, working on the registered X.
  inv_converter_16 u_neg (
    .data_i (x_q),
    .neg_o  (neg_x)
  );

  // Handshake qualifiers and the externally visible status flags.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_GEN);
    accept    = in_valid && in_ready;
    is_last   = (idx_q == IDX_LAST);
    pp_fire   = out_valid && out_ready && is_last ? 1'b1 : 1'b0;
    pp_idx_o  = idx_q;
    pp_last_o = out_valid && is_last;
  end

  // Pick the current Booth window and build the selected multiple of X.
  always_comb begin
    y_ext   = {y_q, 1'b0};
    trip    = y_ext[{1'b0, idx_q, 1'b0} +: 3];
    sel     = booth_decode(trip);
    x_ext   = {{(PP_W - 16){x_q[15]}}, x_q};
    neg_ext = {{(PP_W - 17){neg_x[16]}}, neg_x};
    pp_raw  = '0;
    case (sel)
      SEL_ZERO: pp_raw = '0;
      SEL_PX:   pp_raw = x_ext;
      SEL_P2X:  pp_raw = x_ext << 1;
      SEL_MX:   pp_raw = neg_ext;
      SEL_M2X:  pp_raw = neg_ext << 1;
      default:  pp_raw = '0;
    endcase
    pp_o = out_valid ? pp_raw : '0;
  end

  // Next-state logic: capture operands on accept, step the digit index on
  // each output handshake and return to idle after the final digit.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_GEN;
          x_d     = mcand_i;
          y_d     = mplier_i;
          idx_d   = '0;
        end
      end
      ST_GEN: begin
        if (pp_fire) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (out_valid && out_ready) begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and operand registers, cleared immediately by reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_booth4_pp_seq.sv
// Self-checking bench for booth4_pp_seq: directed table vectors, stall and
// reset sequences, and randomized operands against an arithmetic model.
module tb_booth4_pp_seq;

  localparam int N_RANDOM = 4000;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mcand_i;
  logic [15:0] mplier_i;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] pp_o;
  logic [2:0]  pp_idx_o;
  logic        pp_last_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0]      x;
    logic [15:0]      y;
    logic [7:0][17:0] pp;
  } vec_t;

  vec_t vecs[5];

  // Free-running clock.
  always #5 sys_clk = ~sys_clk;

  booth4_pp_seq dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand_i   (mcand_i),
    .mplier_i  (mplier_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_o      (pp_o),
    .pp_idx_o  (pp_idx_o),
    .pp_last_o (pp_last_o)
  );

  // Booth digit value (-2..+2) times X, straight from the recoding rule.
  function automatic longint ref_pp(input logic [15:0] x, input logic [15:0] y, input int i);
    int hi, mid, lo;
    hi  = int'(y[2*i+1]);
    mid = int'(y[2*i]);
    lo  = (i == 0) ? 0 : int'(y[2*i-1]);
    return longint'(-2 * hi + mid + lo) * longint'($signed(x));
  endfunction

  // One comparison; mismatches are reported and counted.
  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one operand pair and let it be accepted; returns on the
  // negedge after the accepting edge.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y);
    int waited;
    waited    = 0;
    out_ready = 1'b0;
    @(negedge sys_clk);
    while (!in_ready && waited < 50) begin
      @(negedge sys_clk);
      waited++;
    end
    checkOutput("in_ready_before_accept", longint'(in_ready), 1);
    in_valid = 1'b1;
    mcand_i  = x;
    mplier_i = y;
    @(negedge sys_clk);
    in_valid = 1'b0;
    mcand_i  = 16'($urandom);
    mplier_i = 16'($urandom);
    checkOutput("out_valid_after_accept", longint'(out_valid), 1);
    checkOutput("idx_after_accept", longint'(pp_idx_o), 0);
  endtask

  // Drain partial products from start_idx onward with a random out_ready,
  // checking each against the model, stability under stall, and noise on
  // the input port being ignored.
  task automatic collect(input logic [15:0] x, input logic [15:0] y, input int start_idx,
                         input int ready_pct, output longint sum, output logic [7:0][17:0] got);
    int          exp_idx;
    int          cyc;
    logic        done;
    logic        stalled;
    logic        rdy;
    logic [17:0] prev_pp;
    logic [2:0]  prev_idx;
    sum     = 0;
    got     = '0;
    exp_idx = start_idx;
    cyc     = 0;
    done    = 1'b0;
    stalled = 1'b0;
    prev_pp = '0;
    prev_idx = '0;
    while (!done && cyc < 200) begin
      checkOutput("out_valid_in_gen", longint'(out_valid), 1);
      checkOutput("in_ready_in_gen", longint'(in_ready), 0);
      if (stalled) begin
        checkOutput("pp_hold", longint'(pp_o), longint'(prev_pp));
        checkOutput("idx_hold", longint'(pp_idx_o), longint'(prev_idx));
      end
      checkOutput("pp_idx", longint'(pp_idx_o), longint'(exp_idx));
      checkOutput("pp_last", longint'(pp_last_o), longint'(exp_idx == 7));
      checkOutput("pp_value", longint'($signed(pp_o)), ref_pp(x, y, exp_idx));
      rdy       = ($urandom_range(99) < ready_pct);
      out_ready = rdy;
      if (rdy) begin
        got[exp_idx[2:0]] = pp_o;
        sum = sum + longint'($signed(pp_o)) * (longint'(1) << (2 * exp_idx));
        if (exp_idx == 7) done = 1'b1;
        exp_idx++;
        stalled = 1'b0;
        in_valid = done ? 1'b0 : 1'($urandom);
      end else begin
        stalled  = 1'b1;
        prev_pp  = pp_o;
        prev_idx = pp_idx_o;
        in_valid = 1'($urandom);
      end
      mcand_i  = 16'($urandom);
      mplier_i = 16'($urandom);
      @(negedge sys_clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("drain_complete", longint'(done), 1);
    checkOutput("out_valid_after_last", longint'(out_valid), 0);
    checkOutput("in_ready_after_last", longint'(in_ready), 1);
  endtask

  initial begin
    longint           sum;
    longint           part;
    logic [7:0][17:0] got;
    int               waited;

    // Directed vectors with hand-derived partial products.
    for (int v = 0; v < 5; v++) vecs[v] = '0;
    vecs[0].x = 16'h8000; vecs[0].y = 16'h0001; vecs[0].pp[0] = 18'h38000;
    vecs[1].x = 16'h8000; vecs[1].y = 16'h8000; vecs[1].pp[7] = 18'h10000;
    vecs[2].x = 16'h7FFF; vecs[2].y = 16'hFFFF; vecs[2].pp[0] = 18'h38001;
    vecs[3].x = 16'hFFFF; vecs[3].y = 16'h0003; vecs[3].pp[0] = 18'h00001; vecs[3].pp[1] = 18'h3FFFF;
    vecs[4].x = 16'h8000; vecs[4].y = 16'h0002; vecs[4].pp[0] = 18'h10000; vecs[4].pp[1] = 18'h38000;

    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mcand_i   = '0;
    mplier_i  = '0;
    #12;
    checkOutput("reset_in_ready", longint'(in_ready), 1);
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_pp", longint'(pp_o), 0);
    checkOutput("reset_idx", longint'(pp_idx_o), 0);
    checkOutput("reset_last", longint'(pp_last_o), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    $display("[TB] directed vectors");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].x, vecs[v].y);
      collect(vecs[v].x, vecs[v].y, 0, 100, sum, got);
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("vec%0d_pp%0d", v, i), longint'(got[i]), longint'(vecs[v].pp[i]));
      checkOutput($sformatf("vec%0d_sum", v), sum,
                  longint'($signed(vecs[v].x)) * longint'($signed(vecs[v].y)));
    end

    $display("[TB] stall at first digit");
    applyStimulus(16'd3, 16'd2);
    for (int k = 0; k < 3; k++) begin
      checkOutput("stall_valid", longint'(out_valid), 1);
      checkOutput("stall_idx", longint'(pp_idx_o), 0);
      checkOutput("stall_pp", longint'(pp_o), longint'(18'h3FFFA));
      @(negedge sys_clk);
    end
    part = longint'($signed(pp_o));
    out_ready = 1'b1;
    @(negedge sys_clk);
    out_ready = 1'b0;
    checkOutput("after_stall_idx", longint'(pp_idx_o), 1);
    checkOutput("after_stall_pp", longint'(pp_o), 3);
    collect(16'd3, 16'd2, 1, 100, sum, got);
    checkOutput("stall_sum", part + sum, 6);

    $display("[TB] reset in mid-operation");
    applyStimulus(16'h1234, 16'h5678);
    out_ready = 1'b1;
    waited    = 0;
    while (pp_idx_o != 3'd4 && waited < 20) begin
      @(negedge sys_clk);
      waited++;
    end
    checkOutput("reached_idx4", longint'(pp_idx_o), 4);
    sys_rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", longint'(out_valid), 0);
    checkOutput("midrst_in_ready", longint'(in_ready), 1);
    checkOutput("midrst_idx", longint'(pp_idx_o), 0);
    checkOutput("midrst_pp", longint'(pp_o), 0);
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    out_ready = 1'b0;
    @(negedge sys_clk);
    checkOutput("post_rst_out_valid", longint'(out_valid), 0);
    applyStimulus(16'd7, 16'd9);
    collect(16'd7, 16'd9, 0, 100, sum, got);
    checkOutput("post_rst_sum", sum, 63);

    $display("[TB] randomized operands");
    for (int n = 0; n < N_RANDOM; n++) begin
      logic [15:0] rx, ry;
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (n == 0) begin rx = 16'h8000; ry = 16'h8000; end
      applyStimulus(rx, ry);
      collect(rx, ry, 0, 75, sum, got);
      checkOutput("random_sum", sum, longint'($signed(rx)) * longint'($signed(ry)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
